// File: rtl/res_acc_bram.sv
// res_acc_bram: accumulating GEMV result buffer (read-modify-write block RAM) with a zero sweep.
// Ports: clk/rst, clear_start/busy, acc_en/acc_mode/acc_addr/acc_data, rd_en/rd_addr/rd_data/rd_valid, ovf. Option: RES_ACC_SAT_EN.
package accelerator_config_pkg;
  localparam int MAX_ROWS = 16;
endpackage

module res_acc_bram
  import accelerator_config_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = MAX_ROWS,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_start,
  output logic                         busy,
  input  logic                         acc_en,
  input  logic                         acc_mode,
  input  logic [ADDR_WIDTH-1:0]        acc_addr,
  input  logic signed [DATA_WIDTH-1:0] acc_data,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  output logic                         ovf
);

  localparam int W = DATA_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_mode_q, s1_mode_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic signed [W-1:0]   s1_data_q, s1_data_d;
  logic signed [W-1:0]   acc_rd_q, acc_rd_d;

  logic                  fwd_vld_q, fwd_vld_d;
  logic [ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
  logic signed [W-1:0]   fwd_data_q, fwd_data_d;

  logic                  rd_vld_q, rd_vld_d;
  logic signed [W-1:0]   rd_data_q, rd_data_d;

  logic signed [W-1:0] mem [DEPTH];

  logic                  idle;
  logic                  clr_go;
  logic                  acc_fire;
  logic                  rd_fire;
  logic signed [W-1:0]   operand;
  logic signed [W-1:0]   result;
  logic                  of_hit;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic signed [W-1:0]   wdata;

  assign idle     = (state_q == ST_IDLE);
  assign clr_go   = idle & clear_start;
  assign acc_fire = idle & ~clear_start & acc_en;
  assign rd_fire  = idle & ~clear_start & rd_en;

  assign busy     = ~idle;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_vld_q;

  // The RAM still holds the pre-write value for a back-to-back
  // same-row request; take last cycle's committed result instead.
  always_comb begin
    operand = acc_rd_q;
    if (fwd_vld_q && (fwd_addr_q == s1_addr_q))
      operand = fwd_data_q;
  end

`ifdef RES_ACC_SAT_EN
  logic signed [W:0] sum_ext;

  always_comb begin
    sum_ext = {operand[W-1], operand} + {s1_data_q[W-1], s1_data_q};
    of_hit  = 1'b0;
    result  = s1_data_q;
    if (s1_mode_q) begin
      result = sum_ext[W-1:0];
      if (sum_ext[W] != sum_ext[W-1]) begin
        of_hit = 1'b1;
        result = sum_ext[W] ? {1'b1, {(W-1){1'b0}}}
                            : {1'b0, {(W-1){1'b1}}};
      end
    end
  end

  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (s1_vld_q && of_hit)
      ovf_d = 1'b1;
    if (clr_go)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else
      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    of_hit = 1'b0;
    result = s1_data_q;
    if (s1_mode_q)
      result = operand + s1_data_q;
  end

  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (clr_go) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end
  end

  // One write port: the sweep and the S1 commit never overlap,
  // since no request is accepted while sweeping.
  always_comb begin
    we    = 1'b0;
    waddr = s1_addr_q;
    wdata = result;
    if (rst) begin
      we = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      we    = 1'b1;
      waddr = cnt_q;
      wdata = '0;
    end else if (s1_vld_q) begin
      we = 1'b1;
    end
  end

  always_comb begin
    s1_vld_d   = acc_fire;
    s1_mode_d  = acc_fire ? acc_mode : s1_mode_q;
    s1_addr_d  = acc_fire ? acc_addr : s1_addr_q;
    s1_data_d  = acc_fire ? acc_data : s1_data_q;
    acc_rd_d   = acc_fire ? mem[acc_addr] : acc_rd_q;
    fwd_vld_d  = s1_vld_q;
    fwd_addr_d = s1_addr_q;
    fwd_data_d = result;
    rd_vld_d   = rd_fire;
    rd_data_d  = rd_fire ? mem[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      fwd_vld_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= s1_vld_d;
      fwd_vld_q <= fwd_vld_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_mode_q  <= s1_mode_d;
    s1_addr_q  <= s1_addr_d;
    s1_data_q  <= s1_data_d;
    acc_rd_q   <= acc_rd_d;
    fwd_addr_q <= fwd_addr_d;
    fwd_data_q <= fwd_data_d;
  end

endmodule

// File: tb/tb_res_acc_bram.sv
// tb_res_acc_bram: directed self-checking bench for res_acc_bram.
// Covers sweep timing, overwrite/accumulate, forwarding, read-first, saturation, clear and reset.
module tb_res_acc_bram;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = 4;

`ifdef RES_ACC_SAT_EN
  localparam logic [DW-1:0] EXP_POS = 32'h7FFF_FFFF;
  localparam logic [DW-1:0] EXP_NEG = 32'h8000_0000;
  localparam logic          EXP_OVF = 1'b1;
`else
  localparam logic [DW-1:0] EXP_POS = 32'h8000_0010;
  localparam logic [DW-1:0] EXP_NEG = 32'h7FFF_FFF0;
  localparam logic          EXP_OVF = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clear_start = 1'b0;
  logic                 busy;
  logic                 acc_en = 1'b0;
  logic                 acc_mode = 1'b0;
  logic [AW-1:0]        acc_addr = '0;
  logic signed [DW-1:0] acc_data = '0;
  logic                 rd_en = 1'b0;
  logic [AW-1:0]        rd_addr = '0;
  logic signed [DW-1:0] rd_data;
  logic                 rd_valid;
  logic                 ovf;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  res_acc_bram #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEP),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_start(clear_start),
    .busy       (busy),
    .acc_en     (acc_en),
    .acc_mode   (acc_mode),
    .acc_addr   (acc_addr),
    .acc_data   (acc_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .ovf        (ovf)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic m, input logic [AW-1:0] a,
                     input logic signed [DW-1:0] d);
    acc_en   = 1'b1;
    acc_mode = m;
    acc_addr = a;
    acc_data = d;
    tick();
  endtask

  task automatic idle;
    acc_en      = 1'b0;
    rd_en       = 1'b0;
    clear_start = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a,
                         output logic [DW-1:0] d, output logic v);
    acc_en  = 1'b0;
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    d     = rd_data;
    v     = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [DW-1:0] d;
    logic          v;
    for (int i = 0; i < DEP; i++) begin
      do_read(AW'(i), d, v);
      n_total++;
      if ({v, d} !== {1'b1, 32'd0})
        $display("FAIL %s row %0d: valid=%b data=%h, want valid=1 data=0",
                 tag, i, v, d);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if ({busy, rd_valid, rd_data, ovf} !== {1'b1, 1'b0, 32'd0, 1'b0})
      $display("FAIL reset_outputs: busy=%b rv=%b rd=%h ovf=%b, want 1 0 0 0",
               busy, rd_valid, rd_data, ovf);
    else
      n_pass++;
    rst = 1'b0;
    wait_idle(n);
    n_total++;
    if (n !== 16)
      $display("FAIL reset_sweep_len: got %0d cycles, want 16", n);
    else
      n_pass++;
    check_all_zero("reset_zero");
    tick();
    n_total++;
    if (rd_valid !== 1'b0)
      $display("FAIL rd_valid_pulse: got %b, want 0", rd_valid);
    else
      n_pass++;
  endtask

  task automatic test_overwrite_fwd;
    logic [DW-1:0] d;
    logic          v;
    acc(1'b0, 4'd3, 32'sd100);
    acc(1'b1, 4'd3, 32'sd5);
    acc(1'b1, 4'd3, -32'sd20);
    idle();
    do_read(4'd3, d, v);
    n_total++;
    if ({v, d} !== {1'b1, 32'd85})
      $display("FAIL fwd_row3: valid=%b data=%0d, want 1 85", v, $signed(d));
    else
      n_pass++;
  endtask

  task automatic test_interleave;
    logic [DW-1:0] d;
    logic          v;
    acc(1'b1, 4'd1, 32'sd7);
    acc(1'b1, 4'd2, 32'sd9);
    acc(1'b1, 4'd1, 32'sd7);
    idle();
    do_read(4'd1, d, v);
    n_total++;
    if (d !== 32'd14)
      $display("FAIL interleave_row1: got %0d, want 14", d);
    else
      n_pass++;
    do_read(4'd2, d, v);
    n_total++;
    if (d !== 32'd9)
      $display("FAIL interleave_row2: got %0d, want 9", d);
    else
      n_pass++;
  endtask

  task automatic test_read_first;
    logic [DW-1:0] d;
    logic          v;
    acc(1'b0, 4'd3, 32'sd1);
    // S1 commit of row 3 and a read of row 3, plus a new row 7 update
    acc_en   = 1'b1;
    acc_mode = 1'b0;
    acc_addr = 4'd7;
    acc_data = 32'sd42;
    rd_en    = 1'b1;
    rd_addr  = 4'd3;
    tick();
    acc_en = 1'b0;
    rd_en  = 1'b0;
    n_total++;
    if ({rd_valid, rd_data} !== {1'b1, 32'd85})
      $display("FAIL read_first: valid=%b data=%0d, want 1 85",
               rd_valid, rd_data);
    else
      n_pass++;
    tick();
    n_total++;
    if ({rd_valid, rd_data} !== {1'b0, 32'd85})
      $display("FAIL rd_hold: valid=%b data=%0d, want 0 85",
               rd_valid, rd_data);
    else
      n_pass++;
    do_read(4'd3, d, v);
    n_total++;
    if (d !== 32'd1)
      $display("FAIL post_write_row3: got %0d, want 1", d);
    else
      n_pass++;
    do_read(4'd7, d, v);
    n_total++;
    if (d !== 32'd42)
      $display("FAIL same_cycle_row7: got %0d, want 42", d);
    else
      n_pass++;
  endtask

  task automatic test_saturate;
    logic [DW-1:0] d;
    logic          v;
    n_total++;
    if (ovf !== 1'b0)
      $display("FAIL ovf_before_sat: got %b, want 0", ovf);
    else
      n_pass++;
    acc(1'b0, 4'd0, 32'sh7FFF_FFF0);
    acc(1'b1, 4'd0, 32'sh20);
    idle();
    do_read(4'd0, d, v);
    n_total++;
    if (d !== EXP_POS)
      $display("FAIL sat_pos: got %h, want %h", d, EXP_POS);
    else
      n_pass++;
    n_total++;
    if (ovf !== EXP_OVF)
      $display("FAIL ovf_pos: got %b, want %b", ovf, EXP_OVF);
    else
      n_pass++;
    acc(1'b0, 4'd5, 32'sh8000_0010);
    acc(1'b1, 4'd5, -32'sh20);
    idle();
    do_read(4'd5, d, v);
    n_total++;
    if (d !== EXP_NEG)
      $display("FAIL sat_neg: got %h, want %h", d, EXP_NEG);
    else
      n_pass++;
    n_total++;
    if (ovf !== EXP_OVF)
      $display("FAIL ovf_sticky: got %b, want %b", ovf, EXP_OVF);
    else
      n_pass++;
  endtask

  task automatic test_clear;
    int n;
    clear_start = 1'b1;
    acc_en      = 1'b1;
    acc_mode    = 1'b1;
    acc_addr    = 4'd4;
    acc_data    = 32'sd50;
    rd_en       = 1'b1;
    rd_addr     = 4'd3;
    tick();
    clear_start = 1'b0;
    acc_en      = 1'b0;
    rd_en       = 1'b0;
    n_total++;
    if ({busy, rd_valid, ovf} !== 3'b100)
      $display("FAIL clear_accept: busy=%b rv=%b ovf=%b, want 1 0 0",
               busy, rd_valid, ovf);
    else
      n_pass++;
    // a second clear_start mid-sweep must not restart it
    n = 0;
    while (busy && n < 40) begin
      clear_start = (n == 5);
      tick();
      n++;
    end
    clear_start = 1'b0;
    n_total++;
    if (n !== 16)
      $display("FAIL clear_sweep_len: got %0d cycles, want 16", n);
    else
      n_pass++;
    check_all_zero("clear_zero");
  endtask

  task automatic test_rst_mid;
    logic [DW-1:0] d;
    logic          v;
    int            n;
    acc(1'b0, 4'd6, 32'sd123);
    idle();
    do_read(4'd6, d, v);
    n_total++;
    if (d !== 32'd123)
      $display("FAIL pre_rst_row6: got %0d, want 123", d);
    else
      n_pass++;
    acc(1'b1, 4'd6, 32'sd999);
    rst = 1'b1;
    tick();
    acc_en = 1'b0;
    n_total++;
    if ({busy, rd_valid, rd_data, ovf} !== {1'b1, 1'b0, 32'd0, 1'b0})
      $display("FAIL rst_mid_acc: busy=%b rv=%b rd=%h ovf=%b, want 1 0 0 0",
               busy, rd_valid, rd_data, ovf);
    else
      n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    n_total++;
    if ({busy, rd_valid, rd_data, ovf} !== {1'b1, 1'b0, 32'd0, 1'b0})
      $display("FAIL rst_mid_sweep: busy=%b rv=%b rd=%h ovf=%b, want 1 0 0 0",
               busy, rd_valid, rd_data, ovf);
    else
      n_pass++;
    rst = 1'b0;
    wait_idle(n);
    n_total++;
    if (n !== 16)
      $display("FAIL rst_sweep_len: got %0d cycles, want 16", n);
    else
      n_pass++;
    do_read(4'd6, d, v);
    n_total++;
    if ({v, d} !== {1'b1, 32'd0})
      $display("FAIL rst_row6: valid=%b data=%0d, want 1 0", v, d);
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_overwrite_fwd();
    test_interleave();
    test_read_first();
    test_saturate();
    test_clear();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/res_acc_bram.md
# res_acc_bram

Parametrised accumulating result buffer for the GEMV datapath. It replaces the plain write/read result RAM with a read-modify-write accumulator: each partial sum is added into the stored row value. Hazard forwarding allows back-to-back updates to the same row, and a sequenced clear zeroes the array after reset or between layers. It sits between the GEMV MAC tiles and the quantisation/output stage; the array is still inferred as block RAM.

## Interface
- `DATA_WIDTH`, 32: signed accumulator width.
- `DEPTH`, `accelerator_config_pkg::MAX_ROWS`: number of entries.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clear_start` in 1: request full-array zero sweep (pulse).
- `busy` out 1: high while sweeping; update and read requests are ignored.
- `acc_en` in 1: update request valid.
- `acc_mode` in 1: 0 = overwrite with `acc_data`, 1 = add `acc_data` to stored value.
- `acc_addr` in ADDR_WIDTH: update row.
- `acc_data` in DATA_WIDTH signed: write/addend value.
- `rd_en` in 1: read request.
- `rd_addr` in ADDR_WIDTH: read row.
- `rd_data` out DATA_WIDTH signed: read result; holds its value when no read is issued.
- `rd_valid` out 1: one-cycle pulse qualifying `rd_data`.
- `ovf` out 1: sticky saturation flag.

## Operation
- FSM states are CLEAR and IDLE.
- Reset: while `rst` is high, FSM = CLEAR, sweep counter = 0, pipeline is emptied, `busy`=1, `rd_data`=0, `rd_valid`=0, `ovf`=0. Any in-flight update is discarded.
- CLEAR: writes 0 to entry `cnt` every cycle. `cnt` increments by 1 and goes to IDLE after entry DEPTH-1 is written (exactly DEPTH cycles). `busy` falls in the first IDLE cycle.
- IDLE + `clear_start`: goes to CLEAR next cycle and clears `ovf`.
  - A same-cycle `acc_en` or `rd_en` is dropped.
  - An update already in stage 1 commits before the sweep starts.
- `clear_start` while busy: ignored; the sweep is not restarted.
- Update pipeline:
  - S0: request is accepted and memory is read at `acc_addr`.
  - S1: operand = stored value, or the forwarded value (below). Result = `acc_mode` ? operand + `acc_data` : `acc_data`. Result is written at the end of S1.
- Forwarding: if the S1 write address equals the address of the request now entering S1 (a back-to-back same-row request), the previous S1 result replaces the stale RAM value. One register (address, data, valid) covers the single-cycle gap.
- Arithmetic: DATA_WIDTH+1-bit signed sum, reduced per Configuration.
- Read port: read-first. A read of the row being committed this cycle returns the pre-write value. Pending forwarded data is not visible to reads.
- Updates and reads may be issued in the same cycle.

## Timing
- Update throughput: 1 per cycle in IDLE. Latency: request at cycle t, memory updated at end of cycle t+1.
- Read latency 1: `rd_en` at t → `rd_data` and `rd_valid` at t+1.
- A read at cycle t+2 or later observes an update issued at cycle t.
- CLEAR lasts DEPTH cycles after `rst` deasserts or after `clear_start` is accepted.
- Memory contents are never reset directly; only the sweep zeroes them.

## Configuration
- `RES_ACC_SAT_EN` defined: accumulate saturates to the signed DATA_WIDTH max or min, and `ovf` is set (sticky until `rst` or accepted `clear_start`).
- Not defined: the sum wraps modulo 2^DATA_WIDTH and `ovf` is tied to 0.
- Overwrite mode never sets `ovf`.

## Test plan
- Reset then idle, DEPTH=16: `busy`=1 for 16 cycles after `rst` falls, then 0. Reading rows 0..15 returns 0, each `rd_valid` one cycle after `rd_en`.
- Overwrite row 3 with 100, then accumulate +5 and −20 on consecutive cycles to row 3 → a read two cycles later returns 85 (exercises forwarding).
- Interleave: accumulate row 1 +7, row 2 +9, row 1 +7 on consecutive cycles → rows 1/2 read 14/9.
- With `RES_ACC_SAT_EN`: row 0 = 0x7FFFFFF0, accumulate +0x20 → 0x7FFFFFFF and `ovf`=1. Without the macro → 0x80000010 and `ovf`=0.
- `clear_start` in the same cycle as `acc_en` (row 4, +50) → the update is dropped, all rows read 0 after DEPTH cycles, and `ovf` is cleared.
- Assert `rst` mid-sweep and mid-accumulate → outputs return to their reset values, and a full DEPTH-cycle sweep follows deassertion.
